// File: rtl/command_queue.sv
// Captures HPS commands written through the PIO bank using a toggle handshake.
// Commands are buffered in a first-word-fall-through FIFO and handed to the motion executor.
module command_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  flags_out,
  input  logic [W-1:0] cmd_type_in,
  input  logic [W-1:0] cmd_x_in,
  input  logic [W-1:0] cmd_y_in,
  input  logic [W-1:0] cmd_z_in,
  input  logic [W-1:0] cmd_e0_in,
  input  logic [W-1:0] cmd_e1_in,
  input  logic [W-1:0] cmd_f_in,
  input  logic [W-1:0] cmd_t_in,
  input  logic [W-1:0] cmd_dt_in,
  input  logic         exec_busy,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [W-1:0] cmd_type,
  output logic [W-1:0] cmd_x,
  output logic [W-1:0] cmd_y,
  output logic [W-1:0] cmd_z,
  output logic [W-1:0] cmd_e0,
  output logic [W-1:0] cmd_e1,
  output logic [W-1:0] cmd_f,
  output logic [W-1:0] cmd_t,
  output logic [W-1:0] cmd_dt,
  output logic [31:0]  flags_in
);

  localparam int RW = 9 * W;

  logic [RW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          toggle_prev_q, ack_q, ovf_q;

  logic          new_cmd, abort, full, empty, pop, push, drop;
  logic [RW-1:0] head;
  logic [4:0]    count_ext;
  logic          unused_flags;

  assign unused_flags = &{1'b0, flags_out[31:2]};

  always_comb begin
    new_cmd = flags_out[0] ^ toggle_prev_q;
    abort   = flags_out[1];
    full    = (count_q == (AW+1)'(DEPTH));
    empty   = (count_q == '0);
    pop     = cmd_valid & cmd_ready;
    push    = new_cmd & ~abort & (~full | pop);
    drop    = new_cmd & ~abort & full & ~pop;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      toggle_prev_q <= 1'b0;
      ack_q         <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      toggle_prev_q <= flags_out[0];
      // Every toggle is acknowledged, even when dropped or aborted, so the HPS never stalls.
      if (new_cmd) ack_q <= flags_out[0];
      if (abort) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (drop) ovf_q    <= 1'b1;
        count_q <= count_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_type_in, cmd_x_in, cmd_y_in, cmd_z_in, cmd_e0_in,
                          cmd_e1_in, cmd_f_in, cmd_t_in, cmd_dt_in};
    end
  end

  // Masking through cmd_valid keeps outputs at zero after reset without clearing memory.
  assign cmd_valid = ~empty;
  assign head      = cmd_valid ? mem_q[rd_ptr_q] : '0;
  assign {cmd_type, cmd_x, cmd_y, cmd_z, cmd_e0, cmd_e1, cmd_f, cmd_t, cmd_dt} = head;

  assign count_ext = 5'(count_q);
  assign flags_in  = {23'b0, empty & ~exec_busy & ~cmd_valid, count_ext[3:0],
                      ovf_q, empty, full, ack_q};

endmodule

// File: tb/tb_command_queue.sv
// Directed testbench for command_queue: handshake, FIFO order, overflow, abort, wrap and reset.
module tb_command_queue;

  logic        clk;
  logic        reset_n;
  logic [31:0] flags_out;
  logic [31:0] cmd_type_in, cmd_x_in, cmd_y_in, cmd_z_in, cmd_e0_in;
  logic [31:0] cmd_e1_in, cmd_f_in, cmd_t_in, cmd_dt_in;
  logic        exec_busy, cmd_valid, cmd_ready;
  logic [31:0] cmd_type, cmd_x, cmd_y, cmd_z, cmd_e0, cmd_e1, cmd_f, cmd_t, cmd_dt;
  logic [31:0] flags_in;

  int n_checks = 0;
  int n_fail   = 0;
  logic tog = 1'b0;

  command_queue #(.DEPTH(4), .AW(2), .W(32)) dut (
    .clk(clk), .reset_n(reset_n), .flags_out(flags_out),
    .cmd_type_in(cmd_type_in), .cmd_x_in(cmd_x_in), .cmd_y_in(cmd_y_in),
    .cmd_z_in(cmd_z_in), .cmd_e0_in(cmd_e0_in), .cmd_e1_in(cmd_e1_in),
    .cmd_f_in(cmd_f_in), .cmd_t_in(cmd_t_in), .cmd_dt_in(cmd_dt_in),
    .exec_busy(exec_busy), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z),
    .cmd_e0(cmd_e0), .cmd_e1(cmd_e1), .cmd_f(cmd_f), .cmd_t(cmd_t),
    .cmd_dt(cmd_dt), .flags_in(flags_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [31:0] x);
    cmd_type_in = 32'd1;
    cmd_x_in    = x;
    cmd_y_in    = x + 32'd1;
    cmd_z_in    = x + 32'd2;
    cmd_e0_in   = x + 32'd3;
    cmd_e1_in   = x + 32'd4;
    cmd_f_in    = x + 32'd5;
    cmd_t_in    = x + 32'd6;
    cmd_dt_in   = x + 32'd100;
  endtask

  // Present a command and flip the toggle; the caller advances the clock.
  task automatic toggle_cmd(input logic [31:0] x);
    set_cmd(x);
    tog = ~tog;
    flags_out[0] = tog;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flags_out = '0; tog = 1'b0; cmd_ready = 1'b0;
    exec_busy = 1'b1; set_cmd(32'd0);
    #2;
    n_checks++;
    if (flags_in !== 32'h004) begin
      n_fail++; $display("FAIL reset_busy_flags: got %h want %h", flags_in, 32'h004);
    end
    exec_busy = 1'b0;
    #1;
    n_checks++;
    if (flags_in !== 32'h104) begin
      n_fail++; $display("FAIL reset_flags: got %h want %h", flags_in, 32'h104);
    end
    n_checks++;
    if (cmd_valid !== 1'b0 || cmd_x !== 32'd0) begin
      n_fail++; $display("FAIL reset_outputs: valid %b x %h want 0 0", cmd_valid, cmd_x);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    toggle_cmd(32'h1000);
    step();
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_x !== 32'h1000 || cmd_type !== 32'd1 || cmd_dt !== 32'h1064) begin
      n_fail++; $display("FAIL single_data: valid %b x %h type %h dt %h want 1 1000 1 1064",
                         cmd_valid, cmd_x, cmd_type, cmd_dt);
    end
    n_checks++;
    if (flags_in !== 32'h011) begin
      n_fail++; $display("FAIL single_flags: got %h want %h", flags_in, 32'h011);
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    n_checks++;
    if (flags_in !== 32'h105 || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: flags %h valid %b want 105 0", flags_in, cmd_valid);
    end
  endtask

  task automatic test_fill_drain();
    for (int unsigned i = 1; i <= 4; i++) begin
      toggle_cmd(32'(i));
      step();
    end
    n_checks++;
    if (flags_in !== {24'h000_000, 4'd4, 3'b001, tog}) begin
      n_fail++; $display("FAIL full_flags: got %h want %h", flags_in, {24'h0, 4'd4, 3'b001, tog});
    end
    cmd_ready = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_x !== 32'(i) || cmd_dt !== 32'(i + 100)) begin
        n_fail++; $display("FAIL drain_order: valid %b x %h dt %h want 1 %h %h",
                           cmd_valid, cmd_x, cmd_dt, i, i + 100);
      end
      step();
    end
    cmd_ready = 1'b0;
    n_checks++;
    if (flags_in[2] !== 1'b1 || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: empty %b valid %b want 1 0", flags_in[2], cmd_valid);
    end
  endtask

  task automatic test_overflow();
    for (int unsigned i = 10; i <= 13; i++) begin
      toggle_cmd(32'(i));
      step();
    end
    toggle_cmd(32'd14);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    n_checks++;
    if (flags_in[7:0] !== {4'd4, 3'b001, tog} || cmd_x !== 32'd11) begin
      n_fail++; $display("FAIL push_pop_full: flags %h head %h want %h head 11",
                         flags_in[7:0], cmd_x, {4'd4, 3'b001, tog});
    end
    toggle_cmd(32'd99);
    step();
    n_checks++;
    if (flags_in[7:0] !== {4'd4, 3'b101, tog}) begin
      n_fail++; $display("FAIL overflow_flags: got %h want %h", flags_in[7:0], {4'd4, 3'b101, tog});
    end
    cmd_ready = 1'b1;
    for (int unsigned i = 11; i <= 14; i++) begin
      n_checks++;
      if (cmd_x !== 32'(i)) begin
        n_fail++; $display("FAIL overflow_order: got %h want %h", cmd_x, i);
      end
      step();
    end
    cmd_ready = 1'b0;
    n_checks++;
    if (flags_in[3] !== 1'b1 || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL overflow_sticky: ovf %b valid %b want 1 0", flags_in[3], cmd_valid);
    end
  endtask

  task automatic test_abort();
    for (int unsigned i = 20; i <= 22; i++) begin
      toggle_cmd(32'(i));
      step();
    end
    n_checks++;
    if (flags_in[7:4] !== 4'd3) begin
      n_fail++; $display("FAIL abort_pre_count: got %0d want 3", flags_in[7:4]);
    end
    flags_out[1] = 1'b1;
    toggle_cmd(32'd77);
    step();
    flags_out[1] = 1'b0;
    n_checks++;
    if (flags_in !== {31'h82, tog} || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_flags: flags %h valid %b want %h 0", flags_in, cmd_valid, {31'h82, tog});
    end
    step();
    n_checks++;
    if (cmd_valid !== 1'b0 || flags_in[7:4] !== 4'd0) begin
      n_fail++; $display("FAIL abort_no_store: valid %b count %0d want 0 0", cmd_valid, flags_in[7:4]);
    end
    flags_out[1] = 1'b1;
    toggle_cmd(32'd78);
    step();
    toggle_cmd(32'd79);
    step();
    flags_out[1] = 1'b0;
    n_checks++;
    if (flags_in !== {31'h82, tog}) begin
      n_fail++; $display("FAIL abort_held: got %h want %h", flags_in, {31'h82, tog});
    end
  endtask

  task automatic test_wrap();
    logic [31:0] q[$];
    logic        pop_now;
    for (int unsigned i = 0; i < 10; i++) begin
      cmd_ready = (i % 3 != 0);
      pop_now = cmd_ready && (q.size() > 0);
      if (pop_now) begin
        n_checks++;
        if (cmd_x !== q[0]) begin
          n_fail++; $display("FAIL wrap_order: got %h want %h", cmd_x, q[0]);
        end
        void'(q.pop_front());
      end
      toggle_cmd(32'(300 + i));
      if (q.size() < 4) q.push_back(32'(300 + i));
      step();
      n_checks++;
      if (flags_in[7:4] !== 4'(q.size()) || flags_in[3] !== 1'b0) begin
        n_fail++; $display("FAIL wrap_count: count %0d ovf %b want %0d 0",
                           flags_in[7:4], flags_in[3], q.size());
      end
    end
    cmd_ready = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_x !== q[0]) begin
      n_fail++; $display("FAIL wrap_head: valid %b x %h want 1 %h", cmd_valid, cmd_x, q[0]);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (cmd_valid !== 1'b0 || flags_in !== 32'h104) begin
      n_fail++; $display("FAIL midstream_reset: valid %b flags %h want 0 104", cmd_valid, flags_in);
    end
    flags_out = '0; tog = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
    n_checks++;
    if (flags_in !== 32'h104) begin
      n_fail++; $display("FAIL post_reset_empty: got %h want 104", flags_in);
    end
  endtask

  task automatic test_idle();
    exec_busy = 1'b1;
    #1;
    n_checks++;
    if (flags_in[8] !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b want 0", flags_in[8]);
    end
    exec_busy = 1'b0;
    #1;
    n_checks++;
    if (flags_in[8] !== 1'b1) begin
      n_fail++; $display("FAIL idle_free: got %b want 1", flags_in[8]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_abort();
    test_wrap();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
